// File: rtl/ctrl_pkg.sv
// Shared definitions for the multicycle RV64-subset sequencer: state encoding,
// supported opcodes and the ALU control / operand-select encodings.
package ctrl_pkg;

    typedef enum logic [3:0] {
        ST_START     = 4'd0,
        ST_FETCH     = 4'd1,
        ST_DECODE    = 4'd2,
        ST_EXECUTE   = 4'd3,
        ST_ALU_WB    = 4'd4,
        ST_MEM_ADDR  = 4'd5,
        ST_MEM_READ  = 4'd6,
        ST_MEM_WB    = 4'd7,
        ST_MEM_WRITE = 4'd8,
        ST_BRANCH    = 4'd9,
        ST_TRAP      = 4'd10
    } state_t;

    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_LD    = 7'b0000011;
    localparam logic [6:0] OP_SD    = 7'b0100011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;

    // DECODE dispatch: one entry per supported instruction class.
    function automatic state_t dispatch(input logic [6:0] op);
        case (op)
            OP_RTYPE:     dispatch = ST_EXECUTE;
            OP_LD, OP_SD: dispatch = ST_MEM_ADDR;
            OP_BEQ:       dispatch = ST_BRANCH;
            default:      dispatch = ST_TRAP;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_control.sv
// Moore-style multicycle sequencer: one state register drives every datapath
// enable and mux select, handshakes with the shared memory port and counts retirements.
module multicycle_control
    import ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       OpCode,
    input  logic             Zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             IorD,
    output logic             ir_write,
    output logic             pc_write,
    output logic             pc_src,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUOp,
    output logic             RegWrite,
    output logic             MemToReg,
    output logic             illegal,
    output logic [CNT_W-1:0] ret_count
);

    state_t             state_q, state_d;
    logic               retire_d;
    logic [CNT_W-1:0]   cnt_q;

    always_comb begin
        state_d  = state_q;
        retire_d = 1'b0;
        case (state_q)
            ST_START:     state_d = ST_FETCH;
            ST_FETCH:     if (mem_ready) state_d = ST_DECODE;
            ST_DECODE:    state_d = dispatch(OpCode);
            ST_EXECUTE:   state_d = ST_ALU_WB;
            ST_ALU_WB: begin
                state_d  = ST_FETCH;
                retire_d = 1'b1;
            end
            // IR still holds the ld/sd opcode here, so it selects the access type.
            ST_MEM_ADDR:  state_d = (OpCode == OP_LD) ? ST_MEM_READ : ST_MEM_WRITE;
            ST_MEM_READ:  if (mem_ready) state_d = ST_MEM_WB;
            ST_MEM_WB: begin
                state_d  = ST_FETCH;
                retire_d = 1'b1;
            end
            ST_MEM_WRITE: if (mem_ready) begin
                state_d  = ST_FETCH;
                retire_d = 1'b1;
            end
            ST_BRANCH: begin
                state_d  = ST_FETCH;
                retire_d = 1'b1;
            end
            ST_TRAP:      state_d = ST_TRAP;
            default:      state_d = ST_START;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_START;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (retire_d) cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // Outputs decode from state only; mem_ready and Zero gate the PC/IR write enables.
    always_comb begin
        mem_req  = 1'b0;
        mem_we   = 1'b0;
        IorD     = 1'b0;
        ir_write = 1'b0;
        pc_write = 1'b0;
        pc_src   = 1'b0;
        ALUSrcA  = 1'b0;
        ALUSrcB  = SRCB_REG;
        ALUOp    = ALUOP_ADD;
        RegWrite = 1'b0;
        MemToReg = 1'b0;
        illegal  = 1'b0;
        case (state_q)
            ST_FETCH: begin
                mem_req  = 1'b1;
                ALUSrcB  = SRCB_FOUR;
                ir_write = mem_ready;
                pc_write = mem_ready;
            end
            ST_DECODE: begin
                ALUSrcB = SRCB_IMM;
            end
            ST_EXECUTE: begin
                ALUSrcA = 1'b1;
                ALUOp   = ALUOP_FUNCT;
            end
            ST_ALU_WB: begin
                RegWrite = 1'b1;
            end
            ST_MEM_ADDR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
            end
            ST_MEM_READ: begin
                mem_req = 1'b1;
                IorD    = 1'b1;
            end
            ST_MEM_WB: begin
                RegWrite = 1'b1;
                MemToReg = 1'b1;
            end
            ST_MEM_WRITE: begin
                mem_req = 1'b1;
                IorD    = 1'b1;
                mem_we  = 1'b1;
            end
            ST_BRANCH: begin
                ALUSrcA  = 1'b1;
                ALUOp    = ALUOP_SUB;
                pc_src   = 1'b1;
                pc_write = Zero;
            end
            ST_TRAP: begin
                illegal = 1'b1;
            end
            default: ;
        endcase
    end

    assign ret_count = cnt_q;

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multicycle sequencer for the RV64 subset datapath (R-type, ld, sd, beq). It replaces the single-cycle opcode decoder with a Moore-style FSM, so one ALU and one shared instruction/data memory port can be reused across cycles. It drives every datapath enable and mux select, handshakes with the memory port, traps unsupported opcodes and counts retired instructions.

## Interface
Parameters:
- CNT_W, 32, width of retired-instruction counter

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- OpCode  in  7  IR[6:0], valid from DECODE onward
- Zero  in  1  ALU zero flag, sampled in BRANCH
- mem_ready  in  1  memory completes the current access this cycle
- mem_req  out  1  memory access request
- mem_we  out  1  1 = write (sd), 0 = read
- IorD  out  1  memory address: 0 = PC, 1 = ALUOut
- ir_write  out  1  latch IR and old_pc (fetch data valid)
- pc_write  out  1  load PC
- pc_src  out  1  PC source: 0 = ALU result (PC+4), 1 = ALUOut (branch target)
- ALUSrcA  out  1  0 = PC/old_pc, 1 = register A
- ALUSrcB  out  2  00 = register B, 01 = constant 4, 10 = immediate
- ALUOp  out  2  00 add, 01 sub, 10 decode funct fields
- RegWrite  out  1  register file write
- MemToReg  out  1  write-back source: 1 = MDR, 0 = ALUOut
- illegal  out  1  sticky trap flag
- ret_count  out  CNT_W  retired instructions

## Operation
- States: START, FETCH, DECODE, EXECUTE, ALU_WB, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE, BRANCH, TRAP.
- START: all outputs 0 → FETCH next cycle.
- FETCH: mem_req=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00. On mem_ready: ir_write=1, pc_write=1, pc_src=0 → DECODE. Otherwise hold.
- DECODE: ALUSrcA=0 (old_pc), ALUSrcB=10, ALUOp=00 (branch target → ALUOut). Dispatch on OpCode:
  - 0110011 → EXECUTE
  - 0000011 or 0100011 → MEM_ADDR
  - 1100011 → BRANCH
  - any other → TRAP
- EXECUTE: ALUSrcA=1, ALUSrcB=00, ALUOp=10 → ALU_WB.
- ALU_WB: RegWrite=1, MemToReg=0 → FETCH.
- MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next: MEM_READ for ld, MEM_WRITE for sd; OpCode is held stable by IR.
- MEM_READ: mem_req=1, IorD=1, mem_we=0. On mem_ready → MEM_WB.
- MEM_WB: RegWrite=1, MemToReg=1 → FETCH.
- MEM_WRITE: mem_req=1, IorD=1, mem_we=1. On mem_ready → FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, pc_src=1, pc_write=Zero → FETCH.
- TRAP: illegal=1, all other outputs 0. Stays in TRAP until reset.
- Outputs not listed for a state are 0. Outputs are decoded from state; the only input-dependent ones are pc_write/ir_write (mem_ready, Zero).
- ret_count increments by 1 on every transition into FETCH from ALU_WB, MEM_WB, MEM_WRITE or BRANCH. It wraps modulo 2^CNT_W and never increments in TRAP.

## Timing
- Reset (async assert): state=START; ret_count=0; illegal=0; all outputs 0 while rst_n low and in the first cycle after release.
- Zero-wait-state memory gives these cycle counts: R-type 4, ld 5, sd 4, beq 3, counted from FETCH entry to next FETCH entry.
- Each cycle mem_ready is low in a memory state adds one cycle. mem_req, IorD and mem_we stay stable until the handshake cycle.
- mem_ready is ignored outside FETCH/MEM_READ/MEM_WRITE.
- Reset asserted mid-access drops mem_req immediately (asynchronous); the access is abandoned.
- A branch both taken and retired updates the PC and ret_count on the same edge.

## Structure
- Shared package ctrl_pkg:
  - state enum
  - opcode constants (OP_RTYPE, OP_LD, OP_SD, OP_BEQ)
  - ALUOp encodings
  - ALUSrcB encodings
- Single module, no sub-modules. The state register plus the output decode is the whole block.
- ret_count is a plain counter inside the module.

## Test plan
- Reset release, mem_ready=1, R-type 0110011 → START, FETCH, DECODE, EXECUTE, ALU_WB, FETCH; RegWrite high exactly 1 cycle; ret_count=1.
- ld with mem_ready low for 2 cycles in MEM_READ → mem_req/IorD=1 held 3 cycles; RegWrite with MemToReg=1 one cycle later; total 7 cycles.
- sd → mem_we=1 only in MEM_WRITE; RegWrite never asserted; ret_count increments on handshake.
- beq with Zero=1 → pc_write=1, pc_src=1 in BRANCH. With Zero=0 → pc_write=0; ret_count increments in both cases.
- OpCode 0010011 → TRAP; illegal=1, mem_req=0 for 10 cycles, ret_count frozen; rst_n low clears illegal asynchronously.
- Preload ret_count via force to 2^CNT_W−1, retire one instruction → ret_count=0.
